// File: rtl/regression_accum_if.sv
// Sample/result bus for regression_accum: start pulse, sample stream, result handshake and moment vectors.
// Widths follow W, N and DEG exactly as the accumulator derives them.
interface regression_accum_if #(
   parameter int W   = 12,
   parameter int N   = 128,
   parameter int DEG = 2
);
   localparam int ACC_W = 2 * DEG * W + $clog2(N);

   logic                         start;
   logic                         in_valid;
   logic                         in_ready;
   logic [W-1:0]                 x;
   logic [W-1:0]                 y;
   logic                         out_valid;
   logic                         out_ready;
   logic [(2*DEG+1)*ACC_W-1:0]   mom_x;
   logic [(DEG+1)*ACC_W-1:0]     mom_xy;

   modport master (
      output start, in_valid, x, y, out_ready,
      input  in_ready, out_valid, mom_x, mom_xy
   );

   modport slave (
      input  start, in_valid, x, y, out_ready,
      output in_ready, out_valid, mom_x, mom_xy
   );
endinterface

// File: rtl/regression_accum.sv
// Streaming X^T.X / X^T.Y moment accumulator for the Longstaff-Schwartz regression step.
// Optional REGRESSION_ITM_FILTER_EN: samples with y==0 are counted toward N but add to no moment.
module regression_accum #(
   parameter int W   = 12,
   parameter int N   = 128,
   parameter int DEG = 2
) (
   input logic                clk,
   input logic                rst,
   regression_accum_if.slave  bus
);
   localparam int          ACC_W = 2 * DEG * W + $clog2(N);
   localparam int          CNT_W = $clog2(N);
   localparam int unsigned NK_X  = 2 * DEG + 1;
   localparam int unsigned NK_XY = DEG + 1;
   localparam int          W2    = 2 * W;
   localparam int          W3    = 3 * W;
   localparam int          W4    = 4 * W;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        drain_cnt;
   logic              accept, clear, last_accept, drain_end;
   logic              itm_sel;

   logic              s1_valid, s1_inc;
   logic [W-1:0]      s1_x, s1_y;
   logic [W2-1:0]     s1_x2;

   logic              s2_valid, s2_inc;
   logic [W-1:0]      s2_x, s2_y;
   logic [W2-1:0]     s2_x2, s2_xy;

   logic [ACC_W-1:0]  term_x  [NK_X];
   logic [ACC_W-1:0]  term_xy [NK_XY];
   logic [ACC_W-1:0]  acc_x   [NK_X];
   logic [ACC_W-1:0]  acc_xy  [NK_XY];

   assign accept      = bus.in_valid && (state == ACCUM);
   assign clear       = bus.start && (state == IDLE);
   assign last_accept = accept && (cnt == CNT_W'(N - 1));
   assign drain_end   = (state == DRAIN) && (drain_cnt == 2'd2);

`ifdef REGRESSION_ITM_FILTER_EN
   assign itm_sel = (bus.y != '0);
`else
   assign itm_sel = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start)     state_nx = ACCUM;
         ACCUM:   if (last_accept)   state_nx = DRAIN;
         DRAIN:   if (drain_end)     state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default:                    state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == ACCUM);
      bus.out_valid = (state == DONE);
   end

   // Three drain cycles so out_valid rises one edge after the last accumulate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         drain_cnt <= '0;
      end else begin
         if (clear)       cnt <= '0;
         else if (accept) cnt <= cnt + 1'b1;
         if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
         else                drain_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_inc   <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_x2    <= '0;
      end else begin
         s1_valid <= accept;
         s1_inc   <= accept && itm_sel;
         if (accept) begin
            s1_x  <= bus.x;
            s1_y  <= bus.y;
            s1_x2 <= W2'(bus.x) * W2'(bus.x);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_inc   <= 1'b0;
         s2_x     <= '0;
         s2_y     <= '0;
         s2_x2    <= '0;
         s2_xy    <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_inc   <= s1_inc;
         if (s1_valid) begin
            s2_x  <= s1_x;
            s2_y  <= s1_y;
            s2_x2 <= s1_x2;
            s2_xy <= W2'(s1_x) * W2'(s1_y);
         end
      end
   end

   assign term_x[0]  = ACC_W'(1'b1);
   assign term_x[1]  = ACC_W'(s2_x);
   assign term_x[2]  = ACC_W'(s2_x2);
   assign term_xy[0] = ACC_W'(s2_y);
   assign term_xy[1] = ACC_W'(s2_xy);

   generate
      if (DEG == 2) begin : g_deg2
         logic [W3-1:0] s2_x3, s2_x2y;
         logic [W4-1:0] s2_x4;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s2_x3  <= '0;
               s2_x4  <= '0;
               s2_x2y <= '0;
            end else if (s1_valid) begin
               s2_x3  <= W3'(s1_x2) * W3'(s1_x);
               s2_x4  <= W4'(s1_x2) * W4'(s1_x2);
               s2_x2y <= W3'(s1_x2) * W3'(s1_y);
            end
         end

         assign term_x[3]  = ACC_W'(s2_x3);
         assign term_x[4]  = ACC_W'(s2_x4);
         assign term_xy[2] = ACC_W'(s2_x2y);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < NK_X; k++)  acc_x[k]  <= '0;
         for (int unsigned k = 0; k < NK_XY; k++) acc_xy[k] <= '0;
      end else if (clear) begin
         for (int unsigned k = 0; k < NK_X; k++)  acc_x[k]  <= '0;
         for (int unsigned k = 0; k < NK_XY; k++) acc_xy[k] <= '0;
      end else if (s2_valid && s2_inc) begin
         for (int unsigned k = 0; k < NK_X; k++)  acc_x[k]  <= acc_x[k] + term_x[k];
         for (int unsigned k = 0; k < NK_XY; k++) acc_xy[k] <= acc_xy[k] + term_xy[k];
      end
   end

   generate
      for (genvar k = 0; k < NK_X; k++) begin : g_mom_x
         assign bus.mom_x[k*ACC_W +: ACC_W] = acc_x[k];
      end
      for (genvar k = 0; k < NK_XY; k++) begin : g_mom_xy
         assign bus.mom_xy[k*ACC_W +: ACC_W] = acc_xy[k];
      end
   endgenerate
endmodule

// File: tb/tb_regression_accum.sv
// Randomised self-checking bench for regression_accum: DEG=2 and DEG=1 instances share one stimulus stream.
module tb_regression_accum;
   localparam int W    = 12;
   localparam int N    = 4;
   localparam int ACC2 = 2 * 2 * W + $clog2(N);
   localparam int ACC1 = 2 * 1 * W + $clog2(N);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regression_accum_if #(.W(W), .N(N), .DEG(2)) b2 ();
   regression_accum_if #(.W(W), .N(N), .DEG(1)) b1 ();

   assign b1.start     = b2.start;
   assign b1.in_valid  = b2.in_valid;
   assign b1.x         = b2.x;
   assign b1.y         = b2.y;
   assign b1.out_ready = b2.out_ready;

   regression_accum #(.W(W), .N(N), .DEG(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
   regression_accum #(.W(W), .N(N), .DEG(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

   int checks   = 0;
   int failures = 0;

   logic [W-1:0]  sx [N];
   logic [W-1:0]  sy [N];
   logic [63:0]   ex [5];
   logic [63:0]   exy[3];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] mx2(input int k);
      return 64'(b2.mom_x[k*ACC2 +: ACC2]);
   endfunction
   function automatic logic [63:0] mxy2(input int k);
      return 64'(b2.mom_xy[k*ACC2 +: ACC2]);
   endfunction
   function automatic logic [63:0] mx1(input int k);
      return 64'(b1.mom_x[k*ACC1 +: ACC1]);
   endfunction
   function automatic logic [63:0] mxy1(input int k);
      return 64'(b1.mom_xy[k*ACC1 +: ACC1]);
   endfunction

   // Reference: plain power sums over the batch, honouring the in-the-money filter when built with it.
   task automatic model();
      logic [63:0] p;
      bit inc;
      for (int k = 0; k < 5; k++) ex[k] = 0;
      for (int k = 0; k < 3; k++) exy[k] = 0;
      for (int i = 0; i < N; i++) begin
`ifdef REGRESSION_ITM_FILTER_EN
         inc = (sy[i] != 0);
`else
         inc = 1'b1;
`endif
         if (inc) begin
            p = 64'd1;
            for (int k = 0; k < 5; k++) begin
               ex[k] += p;
               if (k < 3) exy[k] += p * 64'(sy[i]);
               p = p * 64'(sx[i]);
            end
         end
      end
   endtask

   task automatic check_moments(input string tag);
      for (int k = 0; k < 5; k++) check($sformatf("%s_d2_mx%0d", tag, k), mx2(k), ex[k]);
      for (int k = 0; k < 3; k++) check($sformatf("%s_d2_mxy%0d", tag, k), mxy2(k), exy[k]);
      for (int k = 0; k < 3; k++) check($sformatf("%s_d1_mx%0d", tag, k), mx1(k), ex[k]);
      for (int k = 0; k < 2; k++) check($sformatf("%s_d1_mxy%0d", tag, k), mxy1(k), exy[k]);
   endtask

   task automatic pulse_start();
      @(negedge clk); b2.start = 1'b1;
      @(negedge clk); b2.start = 1'b0;
   endtask

   // Returns right after the posedge that accepts the last of n samples.
   task automatic feed(input int n, input int gap_mode, output bit ok);
      int g, guard;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((i == 0) ? 0 : 2) : $urandom_range(0, 2);
         repeat (g) begin b2.in_valid = 1'b0; @(negedge clk); end
         b2.in_valid = 1'b1; b2.x = sx[i]; b2.y = sy[i];
         guard = 0;
         while (!b2.in_ready && guard < 20) begin @(negedge clk); guard++; end
         if (guard >= 20) begin
            check("in_ready_timeout", 64'(b2.in_ready), 64'd1);
            b2.in_valid = 1'b0;
            ok = 1'b0;
            return;
         end
         @(posedge clk);
         if (i < n - 1) @(negedge clk);
      end
   endtask

   task automatic latency(input string tag);
      #1;
      b2.in_valid = 1'b0;
      check({tag, "_in_ready_drop"}, 64'(b2.in_ready), 64'd0);
      check({tag, "_ov_t0"}, 64'(b2.out_valid), 64'd0);
      for (int e = 1; e <= 2; e++) begin
         @(posedge clk); #1;
         check($sformatf("%s_ov_t%0d", tag, e), 64'(b2.out_valid), 64'd0);
      end
      @(posedge clk); #1;
      check({tag, "_ov_t3"}, 64'(b2.out_valid), 64'd1);
      check({tag, "_ov1_t3"}, 64'(b1.out_valid), 64'd1);
   endtask

   task automatic run_batch(input string tag, input int gap_mode, input bit ready_early, input int hold);
      bit ok;
      model();
      b2.out_ready = ready_early;
      pulse_start();
      feed(N, gap_mode, ok);
      if (!ok) return;
      latency(tag);
      check_moments(tag);
      if (ready_early) begin
         @(posedge clk); #1;
         check({tag, "_early_hs"}, 64'(b2.out_valid), 64'd0);
         b2.out_ready = 1'b0;
      end else begin
         repeat (hold) begin @(negedge clk); b2.start = 1'($urandom_range(0, 1)); end
         #1;
         check({tag, "_hold_ov"}, 64'(b2.out_valid), 64'd1);
         check({tag, "_hold_mx1"}, mx2(1), ex[1]);
         @(negedge clk); b2.out_ready = 1'b1; b2.start = 1'b1;
         @(posedge clk); #1;
         check({tag, "_hs_ov"}, 64'(b2.out_valid), 64'd0);
         check({tag, "_hs_ir"}, 64'(b2.in_ready), 64'd0);
         @(negedge clk); b2.out_ready = 1'b0; b2.start = 1'b0;
         @(posedge clk); #1;
         check({tag, "_start_ignored"}, 64'(b2.in_ready), 64'd0);
      end
      check({tag, "_keep_mx2"}, mx2(2), ex[2]);
      check({tag, "_keep_mxy1"}, mxy2(1), exy[1]);
   endtask

   task automatic load_set1();
      for (int i = 0; i < N; i++) begin
         sx[i] = W'(i + 1);
         sy[i] = W'(10 * (i + 1));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      b2.start = 1'b0; b2.in_valid = 1'b0; b2.x = '0; b2.y = '0; b2.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(b2.in_ready), 64'd0);
      check("rst_out_valid", 64'(b2.out_valid), 64'd0);
      check("rst_mom_x_nz", 64'(b2.mom_x != '0), 64'd0);
      check("rst_mom_xy_nz", 64'(b2.mom_xy != '0), 64'd0);
      check("rst_d1_mom_x_nz", 64'(b1.mom_x != '0), 64'd0);
      @(negedge clk); rst = 1'b0;

      load_set1();
      run_batch("set1", 0, 1'b0, 10);
      check("set1_c_mx3", mx2(3), 64'd100);
      check("set1_c_mx4", mx2(4), 64'd354);
      check("set1_c_mxy2", mxy2(2), 64'd1000);
      check("set1_c_d1_mx2", mx1(2), 64'd30);

      sy[0] = 0; sy[1] = 20; sy[2] = 0; sy[3] = 40;
      run_batch("set2", 0, 1'b1, 0);
`ifdef REGRESSION_ITM_FILTER_EN
      check("set2_c_mx0", mx2(0), 64'd2);
      check("set2_c_mx4", mx2(4), 64'd272);
      check("set2_c_mxy2", mxy2(2), 64'd720);
`else
      check("set2_c_mx0", mx2(0), 64'd4);
      check("set2_c_mx1", mx2(1), 64'd10);
`endif

      for (int i = 0; i < N; i++) begin sx[i] = '1; sy[i] = '1; end
      run_batch("max", 0, 1'b0, 2);
      check("max_c_mx4", mx2(4), 64'd4 * 64'd4095 * 64'd4095 * 64'd4095 * 64'd4095);
      check("max_c_mxy2", mxy2(2), 64'd4 * 64'd4095 * 64'd4095 * 64'd4095);

      load_set1();
      run_batch("gaps", 1, 1'b0, 10);

      pulse_start();
      feed(2, 0, ok);
      #1; b2.in_valid = 1'b0;
      @(negedge clk); rst = 1'b1;
      #1;
      check("midrst_in_ready", 64'(b2.in_ready), 64'd0);
      check("midrst_out_valid", 64'(b2.out_valid), 64'd0);
      check("midrst_mom_x_nz", 64'(b2.mom_x != '0), 64'd0);
      check("midrst_mom_xy_nz", 64'(b2.mom_xy != '0), 64'd0);
      @(negedge clk); rst = 1'b0;
      run_batch("after_rst", 0, 1'b0, 1);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < N; i++) begin
            sx[i] = W'($urandom_range(0, 4095));
            sy[i] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 4095));
         end
         run_batch($sformatf("rnd%0d", r), 2, 1'(r % 2), int'($urandom_range(0, 5)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
